// File: rtl/dilithium_load_sequencer_pkg.sv
// Shared Dilithium operand sizes, phase identifiers, mode encodings and FSM states
// for the operand-load sequencer.
package dilithium_load_sequencer_pkg;

  localparam int SEED_BITS    = 256;
  localparam int N_COEF       = 256;
  localparam int T0_COEF_BITS = 13;
  localparam int T1_COEF_BITS = 10;

  // Per-level parameters: k, l, packed eta bits, packed z bits, omega
  localparam int L2_K = 4, L2_L = 4, L2_ETA_BITS = 3, L2_Z_BITS = 18, L2_OMEGA = 80;
  localparam int L3_K = 6, L3_L = 5, L3_ETA_BITS = 4, L3_Z_BITS = 20, L3_OMEGA = 55;
  localparam int L5_K = 8, L5_L = 7, L5_ETA_BITS = 3, L5_Z_BITS = 20, L5_OMEGA = 75;

  localparam logic [1:0] MODE_KEYGEN  = 2'b00;
  localparam logic [1:0] MODE_SIGN    = 2'b10;
  localparam logic [1:0] MODE_VERIFY  = 2'b01;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    PH_SEED = 3'd0,
    PH_KEY  = 3'd1,
    PH_TR   = 3'd2,
    PH_S1   = 3'd3,
    PH_S2   = 3'd4,
    PH_T0   = 3'd5,
    PH_T1   = 3'd6,
    PH_Z    = 3'd7
  } phase_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int lvl_k(input int sec_level);
    int r;
    case (sec_level)
      3:       r = L3_K;
      5:       r = L5_K;
      default: r = L2_K;
    endcase
    return r;
  endfunction

  function automatic int lvl_l(input int sec_level);
    int r;
    case (sec_level)
      3:       r = L3_L;
      5:       r = L5_L;
      default: r = L2_L;
    endcase
    return r;
  endfunction

  function automatic int lvl_eta_bits(input int sec_level);
    int r;
    case (sec_level)
      3:       r = L3_ETA_BITS;
      5:       r = L5_ETA_BITS;
      default: r = L2_ETA_BITS;
    endcase
    return r;
  endfunction

  function automatic int lvl_z_bits(input int sec_level);
    int r;
    case (sec_level)
      3:       r = L3_Z_BITS;
      5:       r = L5_Z_BITS;
      default: r = L2_Z_BITS;
    endcase
    return r;
  endfunction

  function automatic int lvl_omega(input int sec_level);
    int r;
    case (sec_level)
      3:       r = L3_OMEGA;
      5:       r = L5_OMEGA;
      default: r = L2_OMEGA;
    endcase
    return r;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int phase_bits(input phase_t phase, input int sec_level);
    int r;
    case (phase)
      PH_S1:   r = lvl_l(sec_level) * N_COEF * lvl_eta_bits(sec_level);
      PH_S2:   r = lvl_k(sec_level) * N_COEF * lvl_eta_bits(sec_level);
      PH_T0:   r = lvl_k(sec_level) * N_COEF * T0_COEF_BITS;
      PH_T1:   r = lvl_k(sec_level) * N_COEF * T1_COEF_BITS;
      PH_Z:    r = lvl_l(sec_level) * N_COEF * lvl_z_bits(sec_level);
      default: r = SEED_BITS;
    endcase
    return r;
  endfunction

  function automatic int phase_words(input phase_t phase, input int sec_level, input int w);
    return ceil_div(phase_bits(phase, sec_level), w);
  endfunction

  // Hint vector: omega position bytes plus one count byte per polynomial of k
  function automatic int h_words(input int sec_level, input int w);
    return ceil_div((lvl_omega(sec_level) + lvl_k(sec_level)) * 8, w);
  endfunction

endpackage

// File: rtl/dilithium_load_sequencer_seq_out_fifo.sv
// Two-entry output FIFO holding {phase, last, data} words awaiting the core.
module seq_out_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves in the same cycle
  assign do_wr = push && (!full || pop);
  assign do_rd = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_wr) wr_ptr_q <= ~wr_ptr_q;
      if (do_rd) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, do_wr} - {1'b0, do_rd};
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/dilithium_load_sequencer.sv
// Walks the per-mode operand phase list, reads each word from the input buffer
// and streams it to the Dilithium core tagged with phase index and last flag.
module dilithium_load_sequencer
  import dilithium_load_sequencer_pkg::*;
#(
  parameter int SEC_LEVEL = 2,
  parameter int W         = 32,
  parameter int MSG_SIZE  = 26400,
  parameter int ADDR_W    = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [1:0]                  mode,
  input  logic [$clog2(MSG_SIZE)-1:0] msg_len,
  output logic                        mem_rd_en,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [W-1:0]                mem_rdata,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [W-1:0]                out_data,
  output logic [2:0]                  out_phase,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int ML_W  = $clog2(MSG_SIZE);
  localparam int CNT_W = (ML_W + 1 > ADDR_W) ? ML_W + 1 : ADDR_W;
  localparam int W_SH  = $clog2(W);
  localparam int ENT_W = W + 4;

  localparam logic [CNT_W-1:0] SEED_WORDS = CNT_W'(phase_words(PH_SEED, SEC_LEVEL, W));
  localparam logic [CNT_W-1:0] S1_WORDS   = CNT_W'(phase_words(PH_S1, SEC_LEVEL, W));
  localparam logic [CNT_W-1:0] S2_WORDS   = CNT_W'(phase_words(PH_S2, SEC_LEVEL, W));
  localparam logic [CNT_W-1:0] T0_WORDS   = CNT_W'(phase_words(PH_T0, SEC_LEVEL, W));
  localparam logic [CNT_W-1:0] T1_WORDS   = CNT_W'(phase_words(PH_T1, SEC_LEVEL, W));
  localparam logic [CNT_W-1:0] Z_WORDS    = CNT_W'(phase_words(PH_Z, SEC_LEVEL, W));
  localparam logic [CNT_W-1:0] H_WORDS    = CNT_W'(h_words(SEC_LEVEL, W));

  // Word count of the phase at order index ord; MSG is always the final slot
  function automatic logic [CNT_W-1:0] order_words(input logic [1:0] md, input logic [2:0] ord,
                                                   input logic [CNT_W-1:0] mw);
    logic [CNT_W-1:0] n;
    n = SEED_WORDS;
    case (md)
      MODE_SIGN: begin
        case (ord)
          3'd3:    n = S1_WORDS;
          3'd4:    n = S2_WORDS;
          3'd5:    n = T0_WORDS;
          3'd6:    n = mw;
          default: n = SEED_WORDS;
        endcase
      end
      MODE_VERIFY: begin
        case (ord)
          3'd2:    n = Z_WORDS;
          3'd3:    n = H_WORDS;
          3'd4:    n = T1_WORDS;
          3'd5:    n = mw;
          default: n = SEED_WORDS;
        endcase
      end
      default: n = SEED_WORDS;
    endcase
    return n;
  endfunction

  state_t              state_q, state_d;
  logic [1:0]          mode_q;
  logic [2:0]          last_ord_q, last_ord_d;
  logic [CNT_W-1:0]    msg_words_q, msg_words_d;
  logic [2:0]          ord_q;
  logic [CNT_W-1:0]    wcnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                err_q;

  logic                vld_p1;
  logic [2:0]          tag_phase_p1;
  logic                tag_last_p1;

  logic                start_ok;
  logic [CNT_W-1:0]    cur_words;
  logic                word_last;
  logic                final_rd;
  logic [1:0]          occ;
  logic                pop;
  logic                space;
  logic                bypass;
  logic                fifo_push;
  logic                fifo_pop;
  logic [ENT_W-1:0]    fifo_din;
  logic [ENT_W-1:0]    fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;
  logic [1:0]          fifo_count;

  assign start_ok    = (state_q == ST_IDLE) && start && (mode != MODE_ILLEGAL);
  assign msg_words_d = (CNT_W'(msg_len) + CNT_W'(W - 1)) >> W_SH;

  always_comb begin
    last_ord_d = 3'd0;
    case (mode)
      MODE_SIGN:   last_ord_d = (msg_len == '0) ? 3'd5 : 3'd6;
      MODE_VERIFY: last_ord_d = (msg_len == '0) ? 3'd4 : 3'd5;
      default:     last_ord_d = 3'd0;
    endcase
  end

  assign cur_words = order_words(mode_q, ord_q, msg_words_q);
  assign word_last = (wcnt_q == cur_words - CNT_W'(1));
  assign final_rd  = word_last && (ord_q == last_ord_q);

  // A same-cycle pop frees a slot, so the stream sustains one word per cycle
  assign out_valid = !fifo_empty || vld_p1;
  assign pop       = out_valid && out_ready;
  assign occ       = fifo_count + {1'b0, vld_p1};
  assign space     = (occ - {1'b0, pop}) < 2'd2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    mem_rd_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        busy      = 1'b1;
        mem_rd_en = space;
        if (space && final_rd) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (pop && (occ == 2'd1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage p0: read issue, address and phase walk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_KEYGEN;
      last_ord_q  <= 3'd0;
      msg_words_q <= '0;
      ord_q       <= 3'd0;
      wcnt_q      <= '0;
      addr_q      <= '0;
      err_q       <= 1'b0;
      vld_p1      <= 1'b0;
    end else begin
      err_q  <= (state_q == ST_IDLE) && start && (mode == MODE_ILLEGAL);
      vld_p1 <= mem_rd_en;
      if (start_ok) begin
        mode_q      <= mode;
        last_ord_q  <= last_ord_d;
        msg_words_q <= msg_words_d;
        ord_q       <= 3'd0;
        wcnt_q      <= '0;
        addr_q      <= '0;
      end else if (mem_rd_en) begin
        addr_q <= addr_q + ADDR_W'(1);
        if (word_last) begin
          wcnt_q <= '0;
          ord_q  <= ord_q + 3'd1;
        end else begin
          wcnt_q <= wcnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Stage p1: tag of the read whose data returns this cycle
  always_ff @(posedge clk) begin
    if (mem_rd_en) begin
      tag_phase_p1 <= ord_q;
      tag_last_p1  <= word_last;
    end
  end

  // Returning data skips the FIFO only when it is empty and the core takes it now
  assign bypass    = fifo_empty && vld_p1 && out_ready;
  assign fifo_pop  = !fifo_empty && out_ready;
  assign fifo_push = vld_p1 && !bypass && (!fifo_full || fifo_pop);
  assign fifo_din  = {tag_phase_p1, tag_last_p1, mem_rdata};

  seq_out_fifo #(
    .WIDTH (ENT_W)
  ) u_out_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    out_data  = '0;
    out_phase = 3'd0;
    out_last  = 1'b0;
    if (!fifo_empty) begin
      {out_phase, out_last, out_data} = fifo_dout;
    end else if (vld_p1) begin
      out_data  = mem_rdata;
      out_phase = tag_phase_p1;
      out_last  = tag_last_p1;
    end
  end

  assign mem_addr = addr_q;
  assign err      = err_q;

endmodule

// File: doc/dilithium_load_sequencer.md
# dilithium_load_sequencer

Operand-load scheduler between the word-addressed input buffer and the Dilithium core's input stream. On `start` it decodes `mode` (keygen/sign/verify), walks a fixed ordered list of operand phases, and fetches each phase's word count from the buffer using 1-cycle-latency reads. It delivers the words to the core over a valid/ready stream, tagged with phase ID and a per-phase last flag. Phase sizes derive from `SEC_LEVEL` and `W` using the shared size constants.

## Interface
- `SEC_LEVEL`, 2: Dilithium level, 2/3/5; selects S1/S2/T0/T1/Z/H sizes.
- `W`, 32: word width, 32 or 64 (64 = high-perf core).
- `MSG_SIZE`, 26400: max message bits.
- `ADDR_W`, 12: buffer word-address width.

- `clk`  in  1  clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `mode`  in  2  00 keygen, 10 sign, 01 verify; 11 illegal.
- `msg_len`  in  $clog2(MSG_SIZE)  message length in bits, sampled with `start`.
- `mem_rd_en`  out  1  buffer read strobe.
- `mem_addr`  out  ADDR_W  buffer word address.
- `mem_rdata`  in  W  read data, valid exactly 1 cycle after `mem_rd_en`.
- `out_valid`  out  1  word available to core.
- `out_ready`  in  1  core accepts word.
- `out_data`  out  W  operand word.
- `out_phase`  out  3  phase ID of `out_data`.
- `out_last`  out  1  final word of current phase.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after final handshake.
- `err`  out  1  one-cycle pulse on `start` with mode 11.

## Operation
- Phase IDs: SEED=0, KEY=1, TR=2, S1=3, S2=4, T0=5, T1=6, Z=7. The second seed-sized slot in SIGN (K) and VERIFY (c) both use ID 1. H and MSG reuse IDs through an order index; `out_phase` is the order index (0..6).
- Phase orders:
  - KEYGEN: seed.
  - SIGN: rho, K, tr, s1, s2, t0, msg.
  - VERIFY: rho, c, z, h, t1, msg.
- Word count per phase: ceil(size/W) for sizes SEED=256 (rho/K/tr/c), S1, S2, T0, T1, Z, H.
- MSG word count is ceil(msg_len/W). If `msg_len`=0, the MSG phase is skipped entirely.
- Addresses are packed contiguously from 0. `mem_addr` increments by 1 per read across all phases.
- States:
  - IDLE: `start` with legal mode goes to ISSUE. With mode 11, raise `err` and stay in IDLE.
  - ISSUE: issue reads; after the final read of the final phase, go to DRAIN.
  - DRAIN: wait until the FIFO is empty and nothing is in flight, then go to DONE.
  - DONE: one cycle, `done`=1, then IDLE.
- Output buffer is a 2-entry FIFO of {phase, last, data}. A read is issued only when occupancy + in-flight < 2 in that cycle, counting a same-cycle pop as freeing a slot.
- An in-flight tag register holds {phase, last} for the outstanding read.
- `start` while busy is ignored, with no `err`.
- `out_data`/`out_phase`/`out_last` stay stable while `out_valid` && !`out_ready`.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0; FIFO empty.
- Reset asserted mid-operation aborts immediately. Any in-flight read data is discarded.
- `start` accepted at edge k:
  - `busy`=1 and first `mem_rd_en` in cycle k+1.
  - First `out_valid` in cycle k+2.
- With `out_ready` held at 1, throughput is one word per cycle, including across phase boundaries (no bubble).
- `done` is asserted the cycle after the final handshake; `busy` drops in that same cycle.
- Backpressure: with `out_ready`=0, at most 2 reads are outstanding or buffered, then `mem_rd_en` stays 0.

## Structure
- Shared package holds:
  - the size constants already defined there;
  - `phase_t` enum;
  - a `phase_words(phase, sec_level, w)` function;
  - mode constants KEYGEN/SIGN/VERIFY.
- Sub-module `seq_out_fifo`: 2-entry FIFO, parameterized width, push/pop/full/empty/count.

## Test plan
- Keygen, W=32, `out_ready`=1:
  - addresses 0..7, 8 words, `out_last` on word 8;
  - `done` at k+10.
- Sign, level 2, W=32, `msg_len`=0:
  - 632 words, phases 0..5, no MSG phase;
  - last address 631; `out_last` at word indices 7, 15, 23, 119, 215, 631.
- Verify, level 2, W=32, `msg_len`=33:
  - 935 words; MSG = 2 words at addresses 933..934;
  - H phase = 21 words.
- Random `out_ready` toggling (50%):
  - data order and count identical to the `out_ready`=1 run;
  - never more than 2 reads outstanding or buffered;
  - outputs stable while stalled.
- `start` with mode 11 → `err` pulse, `busy` stays 0, no `mem_rd_en`. `start` while busy → ignored.
- `rst_n` low at word 300 of a sign run → all outputs 0 asynchronously. A fresh keygen afterwards starts at address 0.
